alu_seq_param: RTL



---
 rtl/alu_seq_param.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_param.sv
// Parametrised ALU with a valid/ready request, registered result/flags {Z,C,N,O} and an output strobe.
// Macro ALU_MUL_EN builds the iterative shift-and-add multiplier; without it code 15 is a NOP.
module alu_seq_param #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FunSel,
    input  logic             WF,
    input  logic             InValid,
    output logic             InReady,
    output logic             OutValid,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut
);
    localparam int unsigned H     = WIDTH / 2;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned SUM_W = WIDTH + 1;

    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

`ifdef ALU_MUL_EN
    typedef enum logic {IDLE, MUL_BUSY} state_e;
    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mul_full_q, mul_full_d;
    logic               mul_wf_q, mul_wf_d;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   mul_lo, mul_hi;
    logic [CNT_W-1:0]   mul_msb;
    logic               mul_last;

    assign InReady = (state_q == IDLE) && Reset;
`else
    assign InReady = Reset;
`endif

    logic             accept;
    logic             full;
    logic [3:0]       op;
    logic [WIDTH-1:0] mask, am, bm, b_add, res;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] msb;
    logic             c_in, cin_add, carry, c_new, o_new;

    assign accept = InValid && InReady;
    assign full   = FunSel[4];
    assign op     = FunSel[3:0];
    assign c_in   = flags_q[2];

    // Single-cycle datapath, evaluated on the low W bits with the upper half masked off.
    always_comb begin
        mask    = full ? '1 : {{(WIDTH-H){1'b0}}, {H{1'b1}}};
        msb     = full ? CNT_W'(WIDTH-1) : CNT_W'(H-1);
        am      = A & mask;
        bm      = B & mask;
        b_add   = (op == 4'd6) ? (~bm & mask) : bm;
        cin_add = (op == 4'd6) ? 1'b1 : ((op == 4'd5) ? c_in : 1'b0);
        sum     = {1'b0, am} + {1'b0, b_add} + SUM_W'(cin_add);
        carry   = full ? sum[WIDTH] : sum[H];
        res     = '0;
        c_new   = c_in;
        o_new   = flags_q[0];
        case (op)
            4'd0:  res = am;
            4'd1:  res = bm;
            4'd2:  res = ~am & mask;
            4'd3:  res = ~bm & mask;
            4'd4, 4'd5, 4'd6: begin
                res   = sum[WIDTH-1:0] & mask;
                c_new = carry;
            end
            4'd7:  res = am & bm;
            4'd8:  res = am | bm;
            4'd9:  res = am ^ bm;
            4'd10: begin
                res   = (am << 1) & mask;
                c_new = am[msb];
            end
            4'd11: begin
                res   = am >> 1;
                c_new = am[0];
            end
            4'd12: begin
                res   = (am >> 1) | (WIDTH'(am[msb]) << msb);
                c_new = am[0];
            end
            4'd13: begin
                res   = ((am << 1) | WIDTH'(c_in)) & mask;
                c_new = am[msb];
            end
            4'd14: begin
                res   = (am >> 1) | (WIDTH'(c_in) << msb);
                c_new = am[0];
            end
            default: res = '0;
        endcase
        if (op == 4'd4 || op == 4'd5)
            o_new = (am[msb] == bm[msb]) && (res[msb] != am[msb]);
        else if (op == 4'd6)
            o_new = (am[msb] != bm[msb]) && (res[msb] != am[msb]);
    end

    // Next-state logic: request acceptance and, when built, one multiply step per cycle.
    always_comb begin
        alu_out_d   = alu_out_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
`ifdef ALU_MUL_EN
        state_d    = state_q;
        mcand_d    = mcand_q;
        prod_d     = prod_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        mul_full_d = mul_full_q;
        mul_wf_d   = mul_wf_q;
        prod_next  = prod_q + (mplier_q[0] ? mcand_q : '0);
        mul_lo     = mul_full_q ? prod_next[WIDTH-1:0]
                                : {{(WIDTH-H){1'b0}}, prod_next[H-1:0]};
        mul_hi     = mul_full_q ? prod_next[2*WIDTH-1:WIDTH]
                                : {{(WIDTH-H){1'b0}}, prod_next[WIDTH-1:H]};
        mul_msb    = mul_full_q ? CNT_W'(WIDTH-1) : CNT_W'(H-1);
        mul_last   = mul_full_q ? (cnt_q == CNT_W'(WIDTH-1)) : (cnt_q == CNT_W'(H-1));
`endif
        if (accept) begin
            if (op == 4'd15) begin
`ifdef ALU_MUL_EN
                state_d    = MUL_BUSY;
                mcand_d    = {{WIDTH{1'b0}}, am};
                mplier_d   = bm;
                prod_d     = '0;
                cnt_d      = '0;
                mul_full_d = full;
                mul_wf_d   = WF;
`else
                out_valid_d = 1'b1;
`endif
            end else begin
                alu_out_d   = res;
                out_valid_d = 1'b1;
                if (WF)
                    flags_d = {(res == '0), c_new, res[msb], o_new};
            end
        end
`ifdef ALU_MUL_EN
        if (state_q == MUL_BUSY) begin
            prod_d   = prod_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (mul_last) begin
                state_d     = IDLE;
                alu_out_d   = mul_lo;
                out_valid_d = 1'b1;
                if (mul_wf_q)
                    flags_d = {(mul_lo == '0), (mul_hi != '0), mul_lo[mul_msb], (mul_hi != '0)};
            end
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            alu_out_q   <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            state_q    <= IDLE;
            mcand_q    <= '0;
            prod_q     <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            mul_full_q <= 1'b0;
            mul_wf_q   <= 1'b0;
`endif
        end else begin
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_MUL_EN
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            prod_q     <= prod_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            mul_full_q <= mul_full_d;
            mul_wf_q   <= mul_wf_d;
`endif
        end
    end

    assign ALUOut   = alu_out_q;
    assign FlagsOut = flags_q;
    assign OutValid = out_valid_q;

endmodule
